// File: rtl/lm70_spi_reader.sv
// LM70 SPI temperature reader: single-shot or periodic 16-bit frames.
// Define LM70_ALARM_EN to enable the thr_hi/thr_lo hysteresis alarm.
module lm70_spi_reader #(
  parameter int CLK_DIV       = 2,
  parameter int SAMPLE_PERIOD = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        auto_en,
  input  logic        sio_in,
  input  logic [7:0]  thr_hi,
  input  logic [7:0]  thr_lo,
  output logic        cs_n,
  output logic        sck,
  output logic [15:0] temp_data,
  output logic        temp_valid,
  output logic        busy,
  output logic        alarm
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CS_SETUP = 3'd1;
  localparam logic [2:0] S_SCK_HI   = 3'd2;
  localparam logic [2:0] S_SCK_LO   = 3'd3;
  localparam logic [2:0] S_CS_HOLD  = 3'd4;

  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int PW = $clog2(SAMPLE_PERIOD);

  logic [2:0]    state;
  logic [DW-1:0] div_cnt;
  logic [3:0]    bit_cnt;
  logic [15:0]   shreg;
  logic [PW-1:0] per_cnt;

  logic per_hit;
  logic trigger;
  logic div_last;
  logic frame_done;

  assign per_hit  = auto_en &&
                    (per_cnt == PW'(SAMPLE_PERIOD - 1));
  assign trigger  = (state == S_IDLE) && (start || per_hit);
  assign div_last = (div_cnt == DW'(CLK_DIV - 1));
  assign frame_done = (state == S_CS_HOLD) && div_last;

  assign cs_n = (state == S_IDLE);
  assign busy = (state != S_IDLE);
  assign sck  = (state == S_SCK_HI);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      temp_data  <= '0;
      temp_valid <= 1'b0;
    end else begin
      temp_valid <= 1'b0;
      if (state == S_IDLE || div_last)
        div_cnt <= '0;
      else
        div_cnt <= div_cnt + 1'b1;
      unique case (1'b1)
        (state == S_IDLE): begin
          if (trigger) begin
            state   <= S_CS_SETUP;
            bit_cnt <= '0;
          end
        end
        (state == S_CS_SETUP): begin
          if (div_last)
            state <= S_SCK_HI;
        end
        (state == S_SCK_HI): begin
          if (div_last) begin
            shreg <= {shreg[14:0], sio_in};
            state <= S_SCK_LO;
          end
        end
        (state == S_SCK_LO): begin
          if (div_last) begin
            bit_cnt <= bit_cnt + 4'd1;
            state   <= (bit_cnt == 4'd15) ? S_CS_HOLD
                                          : S_SCK_HI;
          end
        end
        (state == S_CS_HOLD): begin
          if (div_last) begin
            state      <= S_IDLE;
            temp_data  <= shreg;
            temp_valid <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Free-running only while auto_en; restarts at every frame start
  always_ff @(posedge clk) begin
    if (rst || !auto_en || trigger)
      per_cnt <= '0;
    else if (per_cnt == PW'(SAMPLE_PERIOD - 1))
      per_cnt <= '0;
    else
      per_cnt <= per_cnt + 1'b1;
  end

`ifdef LM70_ALARM_EN
  always_ff @(posedge clk) begin
    if (rst)
      alarm <= 1'b0;
    else if (frame_done) begin
      if (shreg[15:8] >= thr_hi)
        alarm <= 1'b1;
      else if (shreg[15:8] < thr_lo)
        alarm <= 1'b0;
    end
  end
`else
  logic unused_thr;
  logic unused_done;
  assign unused_thr  = ^{thr_hi, thr_lo};
  assign unused_done = frame_done;
  assign alarm       = 1'b0;
`endif

endmodule
